// File: rtl/jericalla_pipe.sv
// jericalla_pipe: two-stage pipelined ALU datapath with a unified register
// file, full forwarding and a valid/ready result stream.
// Ports: clk, rst_n (async, active low)
//        in_valid/in_ready/in_instr  instruction stream {wa,op,ra1,ra2,we}
//        out_valid/out_ready/result/z_flag  result stream
//        retired  count of results handed off downstream
module jericalla_pipe #(
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 4,
  parameter  int CNT_W   = 16,
  localparam int INSTR_W = 3*ADDR_W+5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic               z_flag,
  output logic [CNT_W-1:0]   retired
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int DEPTH = 2**ADDR_W;

  logic [ADDR_W-1:0] w_wa;
  logic [ADDR_W-1:0] w_ra1;
  logic [ADDR_W-1:0] w_ra2;
  logic [3:0]        w_op;
  logic              w_we;

  assign {w_wa, w_op, w_ra1, w_ra2, w_we} = in_instr;

  logic [DATA_W-1:0] r_rf [DEPTH];

  logic              r_s1_valid;
  logic              r_s1_we;
  logic [ADDR_W-1:0] r_s1_wa;
  logic [ADDR_W-1:0] r_s1_ra1;
  logic [ADDR_W-1:0] r_s1_ra2;
  logic [3:0]        r_s1_op;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_result;
  logic              r_z;
  logic [CNT_W-1:0]  r_retired;

  logic              w_adv2;
  logic              w_accept;
  logic              w_fwd;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_imm;
  logic [SH_W-1:0]   w_sh;

  assign w_adv2   = r_s1_valid & (~r_out_valid | out_ready);
  assign in_ready = ~r_s1_valid | w_adv2;
  assign w_accept = in_valid & in_ready;

  // S1 writes back on the same edge a new instr samples the RF,
  // so its result must bypass the stale RF entry.
  assign w_fwd = w_adv2 & r_s1_we;
  assign w_a   = (w_fwd && r_s1_wa == w_ra1) ? w_alu : r_rf[w_ra1];
  assign w_b   = (w_fwd && r_s1_wa == w_ra2) ? w_alu : r_rf[w_ra2];

  assign w_imm = DATA_W'({r_s1_ra1, r_s1_ra2});
  assign w_sh  = r_s1_b[SH_W-1:0];

  always_comb begin
    w_alu = '0;
    unique case (r_s1_op)
      4'h0: w_alu = r_s1_a & r_s1_b;
      4'h1: w_alu = r_s1_a | r_s1_b;
      4'h2: w_alu = r_s1_a + r_s1_b;
      4'h3: w_alu = r_s1_a - r_s1_b;
      4'h4: w_alu = DATA_W'($signed(r_s1_a) < $signed(r_s1_b));
      4'h5: w_alu = ~(r_s1_a | r_s1_b);
      4'h6: w_alu = r_s1_a ^ r_s1_b;
      4'h7: w_alu = r_s1_a << w_sh;
      4'h8: w_alu = r_s1_a >> w_sh;
      4'h9: w_alu = $unsigned($signed(r_s1_a) >>> w_sh);
      4'hA: w_alu = r_s1_a;
      4'hB: w_alu = DATA_W'(r_s1_a < r_s1_b);
      4'hC: w_alu = '0;
      4'hD: w_alu = '0;
      4'hE: w_alu = '0;
      4'hF: w_alu = w_imm;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_we    <= 1'b0;
      r_s1_wa    <= '0;
      r_s1_ra1   <= '0;
      r_s1_ra2   <= '0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_we    <= w_we;
        r_s1_wa    <= w_wa;
        r_s1_ra1   <= w_ra1;
        r_s1_ra2   <= w_ra2;
        r_s1_op    <= w_op;
        r_s1_a     <= w_a;
        r_s1_b     <= w_b;
      end else if (w_adv2) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_z         <= 1'b0;
    end else begin
      if (w_adv2) begin
        r_out_valid <= 1'b1;
        r_result    <= w_alu;
        r_z         <= (w_alu == '0);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_adv2 && r_s1_we) begin
      r_rf[r_s1_wa] <= w_alu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (r_out_valid && out_ready) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign z_flag    = r_z;
  assign retired   = r_retired;

endmodule

// File: tb/tb_jericalla_pipe.sv
// tb_jericalla_pipe: directed bench for jericalla_pipe (CNT_W=4 build)
// with a result scoreboard fed at accept and drained at handoff.
module tb_jericalla_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        z_flag;
  logic [3:0]  retired;

  int chk_pass = 0;
  int chk_total = 0;
  int cyc = 0;
  int mret = 0;
  logic [32:0] sb[$];
  int pop_cyc[$];

  jericalla_pipe #(
    .DATA_W(32),
    .ADDR_W(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_instr(in_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .z_flag(z_flag),
    .retired(retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    chk_total++;
    assert (obs === exp) chk_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("result", result, e[31:0]);
          check("z_flag", 32'(z_flag), 32'(e[32]));
        end
        pop_cyc.push_back(cyc);
        mret++;
      end
    end
  endtask

  task automatic issue(input logic [3:0] wa,
                       input logic [3:0] op,
                       input logic [3:0] ra1,
                       input logic [3:0] ra2,
                       input logic we,
                       input logic [31:0] exp);
    int n;
    n = 0;
    in_instr = {wa, op, ra1, ra2, we};
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    else sb.push_back({(exp == 32'd0), exp});
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
    check("retired", 32'(retired), 32'(mret % 16));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    pop_cyc.delete();
    mret = 0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    fork
      monitor();
    join_none

    repeat (2) step();
    @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_z", 32'(z_flag), 32'd0);
    do_reset();

    // LDI then dependent ADD back-to-back
    issue(4'd1, 4'hF, 4'd0, 4'd5, 1'b1, 32'd5);
    issue(4'd2, 4'h2, 4'd1, 4'd1, 1'b1, 32'd10);
    drain();
    if (pop_cyc.size() >= 2)
      check("t1_consecutive", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
    else
      check("t1_pop_count", 32'(pop_cyc.size()), 32'd2);
    step();

    // SUB zero, SUB wrap, signed/unsigned compares
    issue(4'd3, 4'h3, 4'd1, 4'd1, 1'b1, 32'd0);
    issue(4'd4, 4'h3, 4'd0, 4'd1, 1'b1, 32'hFFFF_FFFB);
    issue(4'd8, 4'h4, 4'd4, 4'd0, 1'b1, 32'd1);
    issue(4'd9, 4'hB, 4'd4, 4'd0, 1'b1, 32'd0);
    drain();
    step();

    // back-pressure: two held, third refused
    out_ready = 1'b0;
    issue(4'd5, 4'h2, 4'd1, 4'd1, 1'b1, 32'd10);
    issue(4'd5, 4'h2, 4'd5, 4'd1, 1'b1, 32'd15);
    in_instr = {4'd5, 4'h2, 4'd5, 4'd1, 1'b1};
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_in_ready", 32'(in_ready), 32'd0);
      check("t3_out_valid", 32'(out_valid), 32'd1);
      check("t3_result_hold", result, 32'd10);
    end
    step();
    out_ready = 1'b1;
    issue(4'd5, 4'h2, 4'd5, 4'd1, 1'b1, 32'd20);
    issue(4'd10, 4'hA, 4'd5, 4'd0, 1'b1, 32'd20);
    drain();
    step();

    // we=0 emits result but leaves RF untouched
    issue(4'd7, 4'h2, 4'd1, 4'd1, 1'b0, 32'd10);
    issue(4'd11, 4'hA, 4'd7, 4'd0, 1'b1, 32'd0);
    drain();
    step();

    // reset with two instrs in flight
    out_ready = 1'b0;
    issue(4'd12, 4'hF, 4'd0, 4'd9, 1'b1, 32'd9);
    issue(4'd13, 4'hF, 4'd0, 4'd7, 1'b1, 32'd7);
    do_reset();
    out_ready = 1'b1;
    issue(4'd14, 4'h2, 4'd1, 4'd12, 1'b1, 32'd0);
    issue(4'd15, 4'hA, 4'd13, 4'd0, 1'b1, 32'd0);
    drain();
    step();

    // counter wrap and shifts
    do_reset();
    for (int i = 0; i < 19; i++) begin
      b = 8'(i);
      issue(4'd6, 4'hF, b[7:4], b[3:0], 1'b1, 32'(i));
    end
    drain();
    check("t6_wrap", 32'(retired), 32'd3);
    step();
    issue(4'd1, 4'hF, 4'd0, 4'd1, 1'b1, 32'd1);
    issue(4'd2, 4'hF, 4'd1, 4'd15, 1'b1, 32'd31);
    issue(4'd3, 4'h7, 4'd1, 4'd2, 1'b1, 32'h8000_0000);
    issue(4'd4, 4'h8, 4'd3, 4'd2, 1'b1, 32'd1);
    issue(4'd4, 4'h9, 4'd3, 4'd2, 1'b1, 32'hFFFF_FFFF);
    issue(4'd5, 4'h6, 4'd4, 4'd1, 1'b1, 32'hFFFF_FFFE);
    issue(4'd5, 4'h5, 4'd5, 4'd2, 1'b1, 32'd0);
    issue(4'd5, 4'hC, 4'd4, 4'd4, 1'b1, 32'd0);
    drain();

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
